// File: rtl/i2c_pkg.sv
// Shared definitions for the i2c bus arbiter and its requesters.
//   - i2c master instruction encodings
//   - arbiter FSM state encoding
//   - magnetic encoder device address and angle register, used by requesters
package i2c_pkg;

   localparam logic [1:0] I2C_START = 2'd0;
   localparam logic [1:0] I2C_STOP  = 2'd1;
   localparam logic [1:0] I2C_READ  = 2'd2;
   localparam logic [1:0] I2C_WRITE = 2'd3;

   typedef enum logic [1:0] {
      ARB_IDLE    = 2'd0,
      ARB_GRANT   = 2'd1,
      ARB_BUSY    = 2'd2,
      ARB_RECOVER = 2'd3
   } arb_state_e;

   localparam logic [6:0] ENC_DEV_ADDR  = 7'h36;
   localparam logic [7:0] ENC_ANGLE_REG = 8'h0C;

endpackage

// File: rtl/i2c_bus_arbiter_if.sv
// Bundle of requester-side and i2c-master-side signals of the arbiter.
//   master : arbiter view (takes requests and master status, drives grants and master commands)
//   slave  : environment view (requesters plus the i2c master engine)
// Per-requester fields are packed: req_instr[2i+1:2i], req_wr_data[8i+7:8i].
interface i2c_bus_arbiter_if #(
   parameter int NUM_REQ = 4
);
   logic [NUM_REQ-1:0]   req_lock;
   logic [NUM_REQ-1:0]   req_cmd_valid;
   logic [2*NUM_REQ-1:0] req_instr;
   logic [8*NUM_REQ-1:0] req_wr_data;
   logic [NUM_REQ-1:0]   req_send_nack;
   logic [NUM_REQ-1:0]   grant;
   logic [NUM_REQ-1:0]   done;
   logic [NUM_REQ-1:0]   timeout;
   logic [7:0]           rd_data;
   logic [7:0]           err_count;
   logic                 i2c_enable;
   logic [1:0]           i2c_instruction;
   logic [7:0]           i2c_byte_to_send;
   logic                 i2c_send_nack;
   logic                 i2c_complete;
   logic [7:0]           i2c_byte_received;

   modport master (
      input  req_lock, req_cmd_valid, req_instr, req_wr_data, req_send_nack,
      input  i2c_complete, i2c_byte_received,
      output grant, done, timeout, rd_data, err_count,
      output i2c_enable, i2c_instruction, i2c_byte_to_send, i2c_send_nack
   );

   modport slave (
      output req_lock, req_cmd_valid, req_instr, req_wr_data, req_send_nack,
      output i2c_complete, i2c_byte_received,
      input  grant, done, timeout, rd_data, err_count,
      input  i2c_enable, i2c_instruction, i2c_byte_to_send, i2c_send_nack
   );
endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin picker.
//   req    : request vector
//   ptr    : index with highest priority; priority falls off ptr, ptr+1, ... mod NUM_REQ
//   winner : one-hot chosen requester (0 when none)
//   valid  : at least one request present
module rr_picker #(
   parameter int NUM_REQ = 4,
   localparam int PTR_W  = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PTR_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] winner,
   output logic               valid
);

   logic [PTR_W-1:0] sel;

   always_comb begin
      winner = '0;
      valid  = 1'b0;
      sel    = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         sel = PTR_W'((int'(ptr) + k) % NUM_REQ);
         if (!valid && req[sel]) begin
            winner[sel] = 1'b1;
            valid       = 1'b1;
         end
      end
   end

endmodule

// File: rtl/i2c_bus_arbiter.sv
// Shares one i2c master between NUM_REQ requesters, one locked transaction at a time.
//   clock, reset_n : clock and synchronous active-low reset
//   bus            : requester lock/command inputs, grant/done/timeout/rd_data/err_count
//                    outputs, and the command/status pair towards the i2c master
// The owner's commands are forwarded one at a time; a watchdog turns a hung command
// into a forced STOP and a forced release of the bus.
module i2c_bus_arbiter
   import i2c_pkg::*;
#(
   parameter int NUM_REQ        = 4,
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic                  clock,
   input  logic                  reset_n,
   i2c_bus_arbiter_if.master     bus
);

   localparam int          PTR_W     = $clog2(NUM_REQ);
   localparam logic [31:0] TIMER_MAX = 32'(TIMEOUT_CYCLES - 1);

   arb_state_e           state_q, state_d;
   logic [NUM_REQ-1:0]   grant_q, grant_d;
   logic [NUM_REQ-1:0]   done_q, done_d;
   logic [NUM_REQ-1:0]   timeout_q, timeout_d;
   logic [7:0]           rd_data_q, rd_data_d;
   logic [7:0]           err_count_q, err_count_d;
   logic                 enable_q, enable_d;
   logic [1:0]           instr_q, instr_d;
   logic [7:0]           byte_q, byte_d;
   logic                 nack_q, nack_d;
   logic [31:0]          timer_q, timer_d;
   logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;

   logic [NUM_REQ-1:0]   pick_winner;
   logic                 pick_valid;
   logic [PTR_W-1:0]     owner;
   logic [PTR_W-1:0]     next_ptr;
   logic                 expired;

   rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
      .req    (bus.req_lock),
      .ptr    (rr_ptr_q),
      .winner (pick_winner),
      .valid  (pick_valid)
   );

   // Owner index recovered from the one-hot grant register.
   always_comb begin
      owner = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (grant_q[k]) begin
            owner = PTR_W'(k);
         end
      end
   end

   // After a release, scanning resumes just past the owner so it cannot re-win first.
   assign next_ptr = (owner == PTR_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
   assign expired  = (timer_q == TIMER_MAX);

   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      done_d      = '0;
      timeout_d   = '0;
      rd_data_d   = rd_data_q;
      err_count_d = err_count_q;
      enable_d    = enable_q;
      instr_d     = instr_q;
      byte_d      = byte_q;
      nack_d      = nack_q;
      timer_d     = timer_q;
      rr_ptr_d    = rr_ptr_q;

      case (state_q)
         ARB_IDLE: begin
            if (pick_valid) begin
               grant_d = pick_winner;
               state_d = ARB_GRANT;
            end
         end

         ARB_GRANT: begin
            // Release outranks a command presented in the same cycle.
            if (!bus.req_lock[owner]) begin
               grant_d  = '0;
               rr_ptr_d = next_ptr;
               state_d  = ARB_IDLE;
            end else if (bus.req_cmd_valid[owner]) begin
               instr_d  = bus.req_instr[{owner, 1'b0} +: 2];
               byte_d   = bus.req_wr_data[{owner, 3'b000} +: 8];
               nack_d   = bus.req_send_nack[owner];
               enable_d = 1'b1;
               timer_d  = '0;
               state_d  = ARB_BUSY;
            end
         end

         ARB_BUSY: begin
            timer_d = timer_q + 32'd1;
            if (bus.i2c_complete) begin
               rd_data_d     = bus.i2c_byte_received;
               done_d[owner] = 1'b1;
               enable_d      = 1'b0;
               state_d       = ARB_GRANT;
            end else if (expired) begin
               timeout_d[owner] = 1'b1;
               if (err_count_q != 8'hFF) begin
                  err_count_d = err_count_q + 8'd1;
               end
               instr_d  = I2C_STOP;
               nack_d   = 1'b0;
               enable_d = 1'b1;
               timer_d  = '0;
               state_d  = ARB_RECOVER;
            end
         end

         ARB_RECOVER: begin
            // The forced STOP ends the transaction whatever the owner's lock says;
            // a second expiry gives up on the master without counting again.
            timer_d = timer_q + 32'd1;
            if (bus.i2c_complete || expired) begin
               enable_d = 1'b0;
               grant_d  = '0;
               rr_ptr_d = next_ptr;
               state_d  = ARB_IDLE;
            end
         end

         default: begin
            state_d = ARB_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q     <= ARB_IDLE;
         grant_q     <= '0;
         done_q      <= '0;
         timeout_q   <= '0;
         rd_data_q   <= '0;
         err_count_q <= '0;
         enable_q    <= 1'b0;
         instr_q     <= '0;
         byte_q      <= '0;
         nack_q      <= 1'b0;
         timer_q     <= '0;
         rr_ptr_q    <= '0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         done_q      <= done_d;
         timeout_q   <= timeout_d;
         rd_data_q   <= rd_data_d;
         err_count_q <= err_count_d;
         enable_q    <= enable_d;
         instr_q     <= instr_d;
         byte_q      <= byte_d;
         nack_q      <= nack_d;
         timer_q     <= timer_d;
         rr_ptr_q    <= rr_ptr_d;
      end
   end

   assign bus.grant            = grant_q;
   assign bus.done             = done_q;
   assign bus.timeout          = timeout_q;
   assign bus.rd_data          = rd_data_q;
   assign bus.err_count        = err_count_q;
   assign bus.i2c_enable       = enable_q;
   assign bus.i2c_instruction  = instr_q;
   assign bus.i2c_byte_to_send = byte_q;
   assign bus.i2c_send_nack    = nack_q;

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Directed bench for i2c_bus_arbiter (NUM_REQ=4, TIMEOUT_CYCLES=16).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_i2c_bus_arbiter;
   import i2c_pkg::*;

   localparam int NUM_REQ = 4;
   localparam int TMO     = 16;

   logic clock;
   logic reset_n;
   int   n_checks;
   int   n_pass;
   int   done_cnt;

   i2c_bus_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

   i2c_bus_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT_CYCLES(TMO)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus.master)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(negedge clock);
   endtask

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One command from owner r; master completes lat cycles after issue returning rx.
   task automatic run_cmd(input int r, input logic [1:0] ins, input logic [7:0] wd,
                          input logic nk, input int lat, input logic [7:0] rx);
      bus.req_cmd_valid[r]       = 1'b1;
      bus.req_instr[2*r +: 2]    = ins;
      bus.req_wr_data[8*r +: 8]  = wd;
      bus.req_send_nack[r]       = nk;
      tick();
      bus.req_cmd_valid[r] = 1'b0;
      check_eq("enable_on_issue", 32'(bus.i2c_enable), 32'd1);
      check_eq("instr_fwd", 32'(bus.i2c_instruction), 32'(ins));
      check_eq("byte_fwd", 32'(bus.i2c_byte_to_send), 32'(wd));
      check_eq("nack_fwd", 32'(bus.i2c_send_nack), 32'(nk));
      repeat (lat - 1) tick();
      bus.i2c_complete      = 1'b1;
      bus.i2c_byte_received = rx;
      tick();
      bus.i2c_complete = 1'b0;
      check_eq("done_pulse", 32'(bus.done), 32'(1 << r));
      check_eq("rd_data", 32'(bus.rd_data), 32'(rx));
      check_eq("enable_off", 32'(bus.i2c_enable), 32'd0);
      $display("txn req=%0d instr=%0d wr=0x%02h nack=%0d rx=0x%02h rd_data=0x%02h",
               r, ins, wd, nk, rx, bus.rd_data);
   endtask

   logic [1:0] enc_ins [9];
   logic [7:0] enc_wd  [9];
   logic       enc_nk  [9];
   logic [7:0] enc_rx  [9];

   initial begin
      n_checks = 0;
      n_pass   = 0;
      done_cnt = 0;
      enc_ins = '{I2C_START, I2C_WRITE, I2C_WRITE, I2C_START, I2C_WRITE,
                  I2C_READ, I2C_READ, I2C_READ, I2C_STOP};
      enc_wd  = '{8'h00, {ENC_DEV_ADDR, 1'b0}, ENC_ANGLE_REG, 8'h00, {ENC_DEV_ADDR, 1'b1},
                  8'h00, 8'h00, 8'h00, 8'h00};
      enc_nk  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      enc_rx  = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h0A, 8'h5B, 8'h5B, 8'h5B};

      reset_n               = 1'b0;
      bus.req_lock          = '0;
      bus.req_cmd_valid     = '0;
      bus.req_instr         = '0;
      bus.req_wr_data       = '0;
      bus.req_send_nack     = '0;
      bus.i2c_complete      = 1'b0;
      bus.i2c_byte_received = '0;
      repeat (2) tick();
      check_eq("rst_grant", 32'(bus.grant), 32'd0);
      check_eq("rst_enable", 32'(bus.i2c_enable), 32'd0);
      check_eq("rst_err", 32'(bus.err_count), 32'd0);
      check_eq("rst_rd_data", 32'(bus.rd_data), 32'd0);

      // Single requester with a non-owner command attempt first.
      reset_n         = 1'b1;
      bus.req_lock[1] = 1'b1;
      tick();
      check_eq("t1_grant", 32'(bus.grant), 32'b0010);
      bus.req_cmd_valid[0] = 1'b1;
      tick();
      bus.req_cmd_valid[0] = 1'b0;
      check_eq("t1_nonowner_ignored", 32'(bus.i2c_enable), 32'd0);
      run_cmd(1, I2C_START, 8'h00, 1'b0, 5, 8'hA5);
      bus.req_lock[1] = 1'b0;
      tick();
      check_eq("t1_release", 32'(bus.grant), 32'd0);

      // Full encoder read on requester 2 while requester 3 waits.
      bus.req_lock[2] = 1'b1;
      tick();
      check_eq("t2_grant", 32'(bus.grant), 32'b0100);
      bus.req_lock[3] = 1'b1;
      for (int i = 0; i < 9; i++) begin
         run_cmd(2, enc_ins[i], enc_wd[i], enc_nk[i], 3, enc_rx[i]);
         if (bus.done == 4'b0100) done_cnt++;
         check_eq("t2_grant_held", 32'(bus.grant), 32'b0100);
      end
      check_eq("t2_done_count", 32'(done_cnt), 32'd9);
      check_eq("t2_final_rd", 32'(bus.rd_data), 32'h5B);
      bus.req_lock[2] = 1'b0;
      tick();
      check_eq("t2_release", 32'(bus.grant), 32'd0);
      tick();
      check_eq("t2_next_owner", 32'(bus.grant), 32'b1000);
      bus.req_lock[3] = 1'b0;
      tick();

      // Fairness: everyone locks; each drops lock for one cycle after its command.
      bus.req_lock = 4'b1111;
      tick();
      for (int i = 0; i < 5; i++) begin
         check_eq("t3_rr_order", 32'(bus.grant), 32'(1 << (i % 4)));
         run_cmd(i % 4, I2C_WRITE, 8'(8'h10 + i), 1'b0, 2, 8'h00);
         bus.req_lock[i % 4] = 1'b0;
         tick();
         if (i < 4) begin
            bus.req_lock[i % 4] = 1'b1;
            tick();
         end
      end
      bus.req_lock = '0;
      tick();

      // Watchdog: requester 1 hangs, requester 3 waits.
      bus.req_lock = 4'b1010;
      tick();
      check_eq("t4_grant", 32'(bus.grant), 32'b0010);
      bus.req_cmd_valid[1]    = 1'b1;
      bus.req_instr[3:2]      = I2C_READ;
      bus.req_send_nack[1]    = 1'b1;
      tick();
      bus.req_cmd_valid[1] = 1'b0;
      repeat (15) tick();
      check_eq("t4_no_early_timeout", 32'(bus.timeout), 32'd0);
      tick();
      check_eq("t4_timeout", 32'(bus.timeout), 32'b0010);
      check_eq("t4_stop_instr", 32'(bus.i2c_instruction), 32'(I2C_STOP));
      check_eq("t4_stop_nack", 32'(bus.i2c_send_nack), 32'd0);
      check_eq("t4_stop_enable", 32'(bus.i2c_enable), 32'd1);
      check_eq("t4_err", 32'(bus.err_count), 32'd1);
      tick();
      check_eq("t4_timeout_pulse", 32'(bus.timeout), 32'd0);
      bus.i2c_complete = 1'b1;
      tick();
      bus.i2c_complete = 1'b0;
      check_eq("t4_forced_release", 32'(bus.grant), 32'd0);
      check_eq("t4_enable_off", 32'(bus.i2c_enable), 32'd0);
      $display("txn req=1 timeout err_count=%0d", bus.err_count);
      tick();
      check_eq("t4_next_locker", 32'(bus.grant), 32'b1000);
      bus.req_lock[1] = 1'b0;

      // Complete lands on the expiry cycle: completion wins.
      bus.req_cmd_valid[3]   = 1'b1;
      bus.req_instr[7:6]     = I2C_WRITE;
      bus.req_wr_data[31:24] = 8'h33;
      tick();
      bus.req_cmd_valid[3] = 1'b0;
      repeat (15) tick();
      bus.i2c_complete      = 1'b1;
      bus.i2c_byte_received = 8'h77;
      tick();
      bus.i2c_complete = 1'b0;
      check_eq("t5_done", 32'(bus.done), 32'b1000);
      check_eq("t5_no_timeout", 32'(bus.timeout), 32'd0);
      check_eq("t5_err_same", 32'(bus.err_count), 32'd1);
      check_eq("t5_rd", 32'(bus.rd_data), 32'h77);
      $display("txn req=3 complete on expiry cycle rd_data=0x%02h", bus.rd_data);
      tick();
      check_eq("t5_no_late_timeout", 32'(bus.timeout), 32'd0);

      // Lock drop together with cmd_valid: release, no command.
      bus.req_lock[3]      = 1'b0;
      bus.req_cmd_valid[3] = 1'b1;
      tick();
      bus.req_cmd_valid[3] = 1'b0;
      check_eq("t5_drop_no_cmd", 32'(bus.i2c_enable), 32'd0);
      check_eq("t5_drop_release", 32'(bus.grant), 32'd0);

      // Reset while a command is in flight.
      bus.req_lock[1] = 1'b1;
      tick();
      check_eq("t6_grant", 32'(bus.grant), 32'b0010);
      bus.req_cmd_valid[1] = 1'b1;
      bus.req_instr[3:2]   = I2C_START;
      tick();
      bus.req_cmd_valid[1] = 1'b0;
      check_eq("t6_busy", 32'(bus.i2c_enable), 32'd1);
      tick();
      reset_n = 1'b0;
      tick();
      check_eq("t6_rst_enable", 32'(bus.i2c_enable), 32'd0);
      check_eq("t6_rst_grant", 32'(bus.grant), 32'd0);
      check_eq("t6_rst_err", 32'(bus.err_count), 32'd0);
      check_eq("t6_rst_rd", 32'(bus.rd_data), 32'd0);
      reset_n         = 1'b1;
      bus.req_lock[1] = 1'b0;
      bus.req_lock[3] = 1'b1;
      tick();
      check_eq("t6_grant3", 32'(bus.grant), 32'b1000);
      $display("txn reset mid-busy then req=3 grant=0x%0h", bus.grant);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/i2c_bus_arbiter.md
Name: i2c_bus_arbiter

Overview:
Shares one i2c master (and its single SCK/SDA pair) between NUM_REQ requesters, e.g. the per-wheel angle controllers that each read their magnetic encoder at device 0x36.
- Grants the bus round-robin per transaction. A transaction is a locked sequence of START/WRITE/READ/NACK/STOP commands.
- Muxes the owner's command into the master and routes completion and received data back.
- A watchdog recovers a hung transaction by forcing a STOP.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
TIMEOUT_CYCLES, 65535, clock cycles allowed per command before timeout (>=2)

Ports:
clock  input  1  main clock
reset_n  input  1  active-low reset, synchronous
req_lock  input  NUM_REQ  requester i wants/holds the bus for a multi-command transaction
req_cmd_valid  input  NUM_REQ  requester i presents a command (honoured only from owner in GRANT)
req_instr  input  2*NUM_REQ  per-requester instruction; slice [2i+1:2i]; 0=START 1=STOP 2=READ 3=WRITE
req_wr_data  input  8*NUM_REQ  per-requester write byte; slice [8i+7:8i]
req_send_nack  input  NUM_REQ  per-requester NACK command flag
grant  output  NUM_REQ  one-hot current owner; 0 when bus is free
done  output  NUM_REQ  1-cycle pulse to owner when its command completes
timeout  output  NUM_REQ  1-cycle pulse to owner on watchdog expiry
rd_data  output  8  byte from the last completed command, broadcast to all requesters
err_count  output  8  saturating count of timeouts
i2c_enable  output  1  command in flight to the master
i2c_instruction  output  2  to master instruction
i2c_byte_to_send  output  8  to master byteToSend
i2c_send_nack  output  1  to master send_nack
i2c_complete  input  1  master complete pulse
i2c_byte_received  input  8  master byteReceived

Behaviour:
- All state and outputs are registered. On reset_n=0 at a clock edge, everything is zeroed:
  - grant, done, timeout, rd_data, err_count, i2c_* outputs = 0
  - state=IDLE, rr_ptr=0, timer=0
- States: IDLE, GRANT, BUSY, RECOVER.
- IDLE:
  - If any req_lock is set, pick the first set index scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - grant goes one-hot on the next edge (1-cycle latency) and the FSM moves to GRANT.
- GRANT (owner o):
  - If req_lock[o]=0: release. Next edge: grant=0, rr_ptr=(o+1) mod NUM_REQ, go to IDLE.
  - Else if req_cmd_valid[o]=1: register req_instr[o], req_wr_data[o], req_send_nack[o] into the i2c_* outputs, set i2c_enable=1, clear timer, go to BUSY. The master sees the command 1 cycle after cmd_valid.
  - Lock-release check has priority over cmd_valid in the same cycle.
- BUSY:
  - i2c_* outputs are held stable; timer increments each cycle.
  - On i2c_complete:
    - rd_data <= i2c_byte_received.
    - done[o] pulses 1 cycle.
    - i2c_enable <= 0; go to GRANT.
  - If timer == TIMEOUT_CYCLES-1 with no complete:
    - timeout[o] pulses.
    - err_count++ (saturate at 255).
    - Load i2c_instruction=STOP, i2c_send_nack=0, i2c_enable=1, clear timer, go to RECOVER.
  - Complete and expiry in the same cycle: complete wins, no timeout.
- RECOVER:
  - On i2c_complete, or on a second expiry (no further count), drop i2c_enable.
  - Force release: grant=0, rr_ptr=(o+1) mod NUM_REQ, go to IDLE. This happens regardless of req_lock.
- Requester rules:
  - Non-owner cmd_valid is ignored.
  - Owner lock drop during BUSY takes effect only after completion, in GRANT.
  - A requester may re-win the bus only after other pending lockers have been scanned.
- Fairness: with all NUM_REQ locking continuously, grants rotate 0,1,2,3,0,...
- i2c_complete in IDLE or GRANT is ignored.
- Reset asserted mid-BUSY: outputs zero on that edge; the master sees i2c_enable=0.

Decomposition:
- Shared package (i2c_pkg):
  - instruction encodings I2C_START=2'd0, I2C_STOP=2'd1, I2C_READ=2'd2, I2C_WRITE=2'd3
  - arbiter state encodings (2-bit)
  - encoder device address 7'h36 and angle register 8'h0C, for requesters
- One combinational sub-module, rr_picker: input req vector and pointer; output one-hot winner and valid.

Test Plan:
- Single requester: req_lock[1]=1, cmd_valid START; master completes 5 cycles later → grant=4'b0010 one cycle after lock, i2c_enable one cycle after cmd_valid, done[1] the cycle after complete, rd_data loaded.
- Full encoder read on requester 2: START, WRITE 0x6C, WRITE 0x0C, START, WRITE 0x6D, READ(returns 0x0A), READ(returns 0x5B), NACK, STOP; lock held throughout → no re-grant, done[2] pulses 9 times, final rd_data=0x5B.
- Fairness: all 4 lock continuously, each runs one command then drops lock for 1 cycle → grant order 0,1,2,3,0; no requester is granted twice before the others.
- Timeout with TIMEOUT_CYCLES=16: master never completes → timeout pulse at cycle 16 after issue, i2c_instruction=STOP; STOP completes → grant=0, err_count=1, next locker granted.
- Simultaneous events: complete on the exact expiry cycle → done pulses, no timeout, err_count unchanged. Lock drop together with cmd_valid in GRANT → release, no command issued.
- Reset mid-BUSY, then lock from requester 3 → all outputs 0, rr_ptr=0, grant=4'b1000 one cycle after lock.
